spi_register_bank: RTL and testbench

Parametrised SPI-slave register file. It is the generalised successor of the byte-wide, 128-entry SPI example device.
- Fully synchronous to one system clock: SPI pins are oversampled.
- Register depth and word width are parameters.
- Supports burst access with address auto-increment and wrap.
- Exposes a local port so on-chip logic can read and write the same registers.
- Sits between the external SPI pins and fabric control/status logic.

---
 rtl/spi_register_bank.sv | 192 +++++++++++++++++++
 tb/tb_spi_register_bank.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_register_bank.sv
// SPI-slave register file (mode 0, MSB first) with burst auto-increment and a local access port.
// Define SPI_REG_WRITE_PROTECT_EN to make addresses >= RO_BASE read-only from the SPI side.
module spi_register_bank #(
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned RO_BASE    = 2 ** (ADDR_WIDTH - 1)
) (
  input  logic                  clock_in,
  input  logic                  reset_in,
  input  logic                  spi_select_in,
  input  logic                  spi_clock_in,
  input  logic                  spi_data_in,
  output logic                  spi_data_out,
  input  logic [ADDR_WIDTH-1:0] local_addr_in,
  input  logic                  local_wr_en_in,
  input  logic [DATA_WIDTH-1:0] local_wr_data_in,
  output logic [DATA_WIDTH-1:0] local_rd_data_out,
  output logic                  spi_wr_strobe_out,
  output logic [ADDR_WIDTH-1:0] spi_wr_addr_out,
  output logic                  spi_busy_out
);

  localparam int unsigned NUM_REGS = 2 ** ADDR_WIDTH;
  localparam int unsigned CmdBits  = ADDR_WIDTH + 1;
  localparam int unsigned ShW      = (CmdBits > DATA_WIDTH) ? CmdBits : DATA_WIDTH;
  localparam int unsigned CntW     = $clog2(ShW);

`ifdef SPI_REG_WRITE_PROTECT_EN
  localparam bit WriteProtect = 1'b1;
`else
  localparam bit WriteProtect = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StCmd, StWrite, StRead} state_e;

  state_e                state_q, state_d;
  logic [1:0]            sel_sync_q, sck_sync_q, mosi_sync_q;
  logic                  sck_prev_q;
  logic                  armed_q;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [ShW-2:0]        rx_q, rx_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  miso_q, miso_d;
  logic                  commit_q, commit_d;
  logic [ADDR_WIDTH-1:0] commit_addr_q, commit_addr_d;
  logic [DATA_WIDTH-1:0] commit_data_q, commit_data_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

  logic                  sel_s, sck_s, mosi_s, sck_rise, sck_fall, spi_writable;
  logic [ShW-1:0]        rx_word;
  logic [DATA_WIDTH-1:0] rd_word;

  assign sel_s    = sel_sync_q[1];
  assign sck_s    = sck_sync_q[1];
  assign mosi_s   = mosi_sync_q[1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign rx_word  = {rx_q, mosi_s};
  assign rd_word  = regs_q[addr_q];

  assign spi_writable = !WriteProtect || (32'(addr_q) < RO_BASE);

  // armed_q blocks a frame until select has been seen high after reset.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      sel_sync_q  <= '0;
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      sel_sync_q  <= {sel_sync_q[0], spi_select_in};
      sck_sync_q  <= {sck_sync_q[0], spi_clock_in};
      mosi_sync_q <= {mosi_sync_q[0], spi_data_in};
      sck_prev_q  <= sck_s;
      armed_q     <= armed_q | sel_s;
    end
  end

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      rx_q          <= '0;
      tx_q          <= '0;
      addr_q        <= '0;
      miso_q        <= 1'b0;
      commit_q      <= 1'b0;
      commit_addr_q <= '0;
      commit_data_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rx_q          <= rx_d;
      tx_q          <= tx_d;
      addr_q        <= addr_d;
      miso_q        <= miso_d;
      commit_q      <= commit_d;
      commit_addr_q <= commit_addr_d;
      commit_data_q <= commit_data_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rx_d          = rx_q;
    tx_d          = tx_q;
    addr_d        = addr_q;
    miso_d        = 1'b0;
    commit_d      = 1'b0;
    commit_addr_d = commit_addr_q;
    commit_data_d = commit_data_q;

    if ((state_q != StIdle) && sel_s) begin
      // Frame aborted: any partially shifted word is simply dropped.
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          cnt_d = '0;
          rx_d  = '0;
          if (!sel_s && armed_q) state_d = StCmd;
        end
        StCmd: begin
          if (sck_rise) begin
            rx_d = rx_word[ShW-2:0];
            if (cnt_q == CntW'(CmdBits - 1)) begin
              cnt_d   = '0;
              addr_d  = rx_word[ADDR_WIDTH-1:0];
              state_d = rx_word[ADDR_WIDTH] ? StRead : StWrite;
            end else begin
              cnt_d = cnt_q + CntW'(1);
            end
          end
        end
        StWrite: begin
          if (sck_rise) begin
            rx_d = rx_word[ShW-2:0];
            if (cnt_q == CntW'(DATA_WIDTH - 1)) begin
              cnt_d  = '0;
              addr_d = addr_q + ADDR_WIDTH'(1);
              if (spi_writable) begin
                commit_d      = 1'b1;
                commit_addr_d = addr_q;
                commit_data_d = rx_word[DATA_WIDTH-1:0];
              end
            end else begin
              cnt_d = cnt_q + CntW'(1);
            end
          end
        end
        StRead: begin
          miso_d = miso_q;
          if (sck_fall) begin
            if (cnt_q == '0) begin
              // Word is captured here, so later local writes cannot corrupt it.
              tx_d   = {rd_word[DATA_WIDTH-2:0], 1'b0};
              miso_d = rd_word[DATA_WIDTH-1];
              addr_d = addr_q + ADDR_WIDTH'(1);
              cnt_d  = CntW'(1);
            end else begin
              tx_d   = {tx_q[DATA_WIDTH-2:0], 1'b0};
              miso_d = tx_q[DATA_WIDTH-1];
              cnt_d  = (cnt_q == CntW'(DATA_WIDTH - 1)) ? '0 : cnt_q + CntW'(1);
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // SPI commit is assigned last so it wins a same-address collision.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      if (local_wr_en_in) regs_q[local_addr_in] <= local_wr_data_in;
      if (commit_q) regs_q[commit_addr_q] <= commit_data_q;
    end
  end

  assign local_rd_data_out = regs_q[local_addr_in];
  assign spi_data_out      = miso_q & (state_q == StRead);
  assign spi_wr_strobe_out = commit_q;
  assign spi_wr_addr_out   = commit_addr_q;
  assign spi_busy_out      = armed_q & ~sel_s;

endmodule

// File: tb/tb_spi_register_bank.sv
// Directed bench for spi_register_bank: SPI bursts, wrap, abort, collisions and reset mid-frame.
module tb_spi_register_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic       sel, sck, mosi, miso;
  logic [6:0] local_addr;
  logic       local_wr_en;
  logic [7:0] local_wr_data, local_rd_data;
  logic       strobe, busy;
  logic [6:0] strobe_addr;

  int checks   = 0;
  int failures = 0;
  logic [6:0] strobe_log[$];

  spi_register_bank dut (
    .clock_in         (clk),
    .reset_in         (rst),
    .spi_select_in    (sel),
    .spi_clock_in     (sck),
    .spi_data_in      (mosi),
    .spi_data_out     (miso),
    .local_addr_in    (local_addr),
    .local_wr_en_in   (local_wr_en),
    .local_wr_data_in (local_wr_data),
    .local_rd_data_out(local_rd_data),
    .spi_wr_strobe_out(strobe),
    .spi_wr_addr_out  (strobe_addr),
    .spi_busy_out     (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (strobe) strobe_log.push_back(strobe_addr);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic local_write(input logic [6:0] a, input logic [7:0] d);
    @(negedge clk);
    local_addr    = a;
    local_wr_data = d;
    local_wr_en   = 1'b1;
    @(negedge clk);
    local_wr_en   = 1'b0;
  endtask

  task automatic local_expect(input string tag, input logic [6:0] a, input logic [7:0] d);
    @(negedge clk);
    local_addr = a;
    #1 check_eq(tag, {24'h0, local_rd_data}, {24'h0, d});
  endtask

  // One mode-0 bit: MISO is sampled just before the rising edge.
  task automatic spi_bit(input logic b, output logic so);
    mosi = b;
    repeat (4) @(negedge clk);
    so  = miso;
    sck = 1'b1;
    repeat (4) @(negedge clk);
    sck = 1'b0;
  endtask

  task automatic spi_word(input logic [31:0] w, input int n, output logic [31:0] r);
    logic b;
    r = '0;
    for (int i = n - 1; i >= 0; i--) begin
      spi_bit(w[i], b);
      r = {r[30:0], b};
    end
  endtask

  task automatic spi_start();
    @(negedge clk);
    sel = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic spi_stop();
    repeat (4) @(negedge clk);
    sel = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // SPI writes 0x77 to addr 3 while a local write lands in the commit cycle.
  task automatic spi_collide(input string tag, input logic [6:0] la, input logic [7:0] ld);
    logic [31:0] r;
    logic        seen;
    seen = 1'b0;
    spi_start();
    spi_word(32'h03, 8, r);
    spi_word(32'h77 >> 1, 7, r);
    mosi = 1'b1;
    repeat (4) @(negedge clk);
    sck = 1'b1;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      if (strobe) begin
        seen          = 1'b1;
        local_addr    = la;
        local_wr_data = ld;
        local_wr_en   = 1'b1;
        @(negedge clk);
        local_wr_en   = 1'b0;
      end
    end
    check_eq(tag, {31'h0, seen}, 32'h1);
    repeat (2) @(negedge clk);
    sck = 1'b0;
    spi_stop();
  endtask

  initial begin
    logic [31:0] r;
    rst = 1'b1; sel = 1'b1; sck = 1'b0; mosi = 1'b0;
    local_addr = '0; local_wr_en = 1'b0; local_wr_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Reset state
    for (int a = 0; a < 128; a++) local_expect("reset_reg", 7'(a), 8'h00);
    check_eq("reset_miso", {31'h0, miso}, 32'h0);
    check_eq("reset_busy", {31'h0, busy}, 32'h0);
    check_eq("reset_strobe", {31'h0, strobe}, 32'h0);

    // Burst write
    strobe_log.delete();
    spi_start();
    spi_word(32'h05, 8, r);
    check_eq("busy_in_frame", {31'h0, busy}, 32'h1);
    check_eq("miso_in_write", {31'h0, miso}, 32'h0);
    spi_word(32'hA5, 8, r);
    spi_word(32'h3C, 8, r);
    spi_stop();
    local_expect("wr_reg5", 7'd5, 8'hA5);
    local_expect("wr_reg6", 7'd6, 8'h3C);
    check_eq("wr_strobes", strobe_log.size(), 32'd2);
    if (strobe_log.size() == 2) begin
      check_eq("wr_strobe_addr0", {25'h0, strobe_log[0]}, 32'd5);
      check_eq("wr_strobe_addr1", {25'h0, strobe_log[1]}, 32'd6);
    end
    check_eq("busy_after_frame", {31'h0, busy}, 32'h0);

    // Read burst with wrap
    local_write(7'd126, 8'h11);
    local_write(7'd127, 8'h22);
    local_write(7'd0, 8'h33);
    strobe_log.delete();
    spi_start();
    spi_word(32'hFE, 8, r);
    spi_word(32'h0, 8, r);
    check_eq("rd_word0", r, 32'h11);
    local_write(7'd0, 8'h44);
    spi_word(32'h0, 8, r);
    check_eq("rd_word1", r, 32'h22);
    spi_word(32'h0, 8, r);
    check_eq("rd_word2_wrap", r, 32'h44);
    spi_stop();
    check_eq("miso_idle_after_read", {31'h0, miso}, 32'h0);
    check_eq("rd_no_strobe", strobe_log.size(), 32'd0);
    local_write(7'd0, 8'h33);

    // Partial word discarded, then a clean frame works
    strobe_log.delete();
    spi_start();
    spi_word(32'h10, 8, r);
    spi_word(32'h1F, 5, r);
    spi_stop();
    local_expect("partial_reg16", 7'd16, 8'h00);
    check_eq("partial_no_strobe", strobe_log.size(), 32'd0);
    check_eq("partial_busy", {31'h0, busy}, 32'h0);
    spi_start();
    spi_word(32'h11, 8, r);
    spi_word(32'h5A, 8, r);
    spi_stop();
    local_expect("after_partial_reg17", 7'd17, 8'h5A);

    // Same-cycle SPI commit and local write
    spi_collide("collide_same_seen", 7'd3, 8'h99);
    local_expect("collide_same_reg3", 7'd3, 8'h77);
    local_write(7'd3, 8'h00);
    local_expect("collide_clear_reg3", 7'd3, 8'h00);
    spi_collide("collide_diff_seen", 7'd4, 8'h99);
    local_expect("collide_diff_reg3", 7'd3, 8'h77);
    local_expect("collide_diff_reg4", 7'd4, 8'h99);

    // Write at top address wraps to 0; protected build drops addr 127
    strobe_log.delete();
    spi_start();
    spi_word(32'h7F, 8, r);
    spi_word(32'h55, 8, r);
    spi_word(32'h66, 8, r);
    spi_stop();
    local_expect("wrap_reg0", 7'd0, 8'h66);
`ifdef SPI_REG_WRITE_PROTECT_EN
    local_expect("prot_reg127", 7'd127, 8'h22);
    check_eq("prot_strobes", strobe_log.size(), 32'd1);
    if (strobe_log.size() == 1) check_eq("prot_strobe_addr", {25'h0, strobe_log[0]}, 32'd0);
`else
    local_expect("wrap_reg127", 7'd127, 8'h55);
    check_eq("wrap_strobes", strobe_log.size(), 32'd2);
    if (strobe_log.size() == 2) begin
      check_eq("wrap_strobe_addr0", {25'h0, strobe_log[0]}, 32'd127);
      check_eq("wrap_strobe_addr1", {25'h0, strobe_log[1]}, 32'd0);
    end
`endif

    // Reset mid-frame: no frame until select is seen high again
    spi_start();
    spi_word(32'h5, 3, r);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    strobe_log.delete();
    local_expect("midreset_reg5", 7'd5, 8'h00);
    spi_word(32'h08, 8, r);
    check_eq("midreset_busy", {31'h0, busy}, 32'h0);
    spi_word(32'hEE, 8, r);
    spi_stop();
    local_expect("midreset_reg8", 7'd8, 8'h00);
    check_eq("midreset_no_strobe", strobe_log.size(), 32'd0);
    spi_start();
    spi_word(32'h08, 8, r);
    spi_word(32'hEE, 8, r);
    spi_stop();
    local_expect("rearmed_reg8", 7'd8, 8'hEE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
